// File: rtl/byte_serial_transmitter_pkg.sv
// Shared types and constants for the JTAG serial transmitter.
// Provides the FSM state encoding and the default IDCODE word.
package byte_serial_transmitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [31:0] IDCODE_DEFAULT = 32'h000F_AF01;

endpackage

// File: rtl/byte_serial_transmitter.sv
// Parallel-in/serial-out transmitter, one bit per enabled clock.
// Ports: clk, reset_n (sync, active-low), enable, in[WIDTH-1:0],
//        out (registered serial bit), done (sticky until reset).
// Build option: MSB_FIRST_EN reverses the bit order (MSB first).
module byte_serial_transmitter
    import byte_serial_transmitter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic             out,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_q, out_d;
    logic             done_q, done_d;

    // The register holds the not-yet-sent bits aligned so the next one
    // always sits at a fixed end; this keeps the output mux a single tap.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        out_d   = out_q;
        done_d  = done_q;
        if (enable) begin
            unique case (state_q)
                IDLE: begin
`ifdef MSB_FIRST_EN
                    out_d   = in[WIDTH-1];
                    shreg_d = in << 1;
`else
                    out_d   = in[0];
                    shreg_d = in >> 1;
`endif
                    count_d = CW'(1);
                    if (WIDTH == 1) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
`ifdef MSB_FIRST_EN
                    out_d   = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
`else
                    out_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
`endif
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    out_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;

endmodule

// File: tb/tb_byte_serial_transmitter.sv
// Self-checking bench for byte_serial_transmitter (WIDTH=32).
// Reference: expected bit = word bit chosen by enabled-edge number.
module tb_byte_serial_transmitter;
    import byte_serial_transmitter_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic [W-1:0] din;
    logic         dout;
    logic         done;

    int pass_cnt;
    int total_cnt;

    logic [W-1:0] word_m;
    int           n_m;

    byte_serial_transmitter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .in      (din),
        .out     (dout),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_out(int n);
        if (n == 0 || n > W) return 1'b0;
`ifdef MSB_FIRST_EN
        return word_m[W - n];
`else
        return word_m[n - 1];
`endif
    endfunction

    function automatic logic exp_done(int n);
        return n >= W;
    endfunction

    task automatic step(input logic en);
        enable = en;
        @(posedge clk);
        if (!reset_n) n_m = 0;
        else if (en) begin
            if (n_m == 0) word_m = din;
            n_m++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1'b0);
        step(1'b0);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        din = $urandom;
        for (int i = 0; i < 2; i++) begin
            step(1'b1);
            total_cnt++;
            if (dout !== 1'b0 || done !== 1'b0)
                $display("FAIL reset_active out=%b done=%b want 0 0", dout, done);
            else pass_cnt++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            total_cnt++;
            if (dout !== 1'b0 || done !== 1'b0)
                $display("FAIL reset_hold out=%b done=%b want 0 0", dout, done);
            else pass_cnt++;
        end
    endtask

    task automatic test_idcode();
        do_reset();
        din = IDCODE_DEFAULT;
        for (int i = 0; i < W; i++) begin
            step(1'b1);
            total_cnt++;
            if (dout !== exp_out(n_m) || done !== exp_done(n_m))
                $display("FAIL idcode_edge%0d out=%b done=%b want %b %b",
                         n_m, dout, done, exp_out(n_m), exp_done(n_m));
            else pass_cnt++;
        end
    endtask

    task automatic test_pause();
        do_reset();
        din = IDCODE_DEFAULT;
        for (int i = 0; i < W; i++) begin
            step(1'b1);
            if (i == 9) begin
                for (int j = 0; j < 5; j++) begin
                    step(1'b0);
                    total_cnt++;
                    if (dout !== exp_out(10) || done !== 1'b0 || n_m != 10)
                        $display("FAIL pause_frozen out=%b done=%b want %b 0",
                                 dout, done, exp_out(10));
                    else pass_cnt++;
                end
            end
            total_cnt++;
            if (dout !== exp_out(n_m) || done !== exp_done(n_m))
                $display("FAIL pause_edge%0d out=%b done=%b want %b %b",
                         n_m, dout, done, exp_out(n_m), exp_done(n_m));
            else pass_cnt++;
        end
    endtask

    task automatic test_sticky_done();
        din = '1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1);
            total_cnt++;
            if (dout !== 1'b0 || done !== 1'b1)
                $display("FAIL sticky_done out=%b done=%b want 0 1", dout, done);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_shift();
        do_reset();
        din = $urandom;
        for (int i = 0; i < 14; i++) step(1'b1);
        reset_n = 1'b0;
        step(1'b1);
        reset_n = 1'b1;
        total_cnt++;
        if (dout !== 1'b0 || done !== 1'b0)
            $display("FAIL midreset out=%b done=%b want 0 0", dout, done);
        else pass_cnt++;
        din = $urandom;
        for (int i = 0; i < W; i++) begin
            step(1'b1);
            din = $urandom;
            total_cnt++;
            if (dout !== exp_out(n_m) || done !== exp_done(n_m))
                $display("FAIL midreset_edge%0d out=%b done=%b want %b %b",
                         n_m, dout, done, exp_out(n_m), exp_done(n_m));
            else pass_cnt++;
        end
    endtask

    task automatic test_edge_pattern();
        do_reset();
        din = 32'h8000_0001;
        for (int i = 0; i < W + 2; i++) begin
            step(1'b1);
            total_cnt++;
            if (dout !== exp_out(n_m) || done !== exp_done(n_m))
                $display("FAIL pattern_edge%0d out=%b done=%b want %b %b",
                         n_m, dout, done, exp_out(n_m), exp_done(n_m));
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int w = 0; w < 20; w++) begin
            do_reset();
            din = $urandom;
            for (int c = 0; c < 200 && n_m < W + 3; c++) begin
                step($urandom_range(0, 9) < 7);
                din = $urandom;
                total_cnt++;
                if (dout !== exp_out(n_m) || done !== exp_done(n_m))
                    $display("FAIL random_w%0d_n%0d out=%b done=%b want %b %b",
                             w, n_m, dout, done, exp_out(n_m), exp_done(n_m));
                else pass_cnt++;
            end
            total_cnt++;
            if (n_m < W + 3)
                $display("FAIL random_w%0d_budget edges=%0d want >=%0d",
                         w, n_m, W + 3);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        n_m       = 0;
        word_m    = '0;
        reset_n   = 1'b0;
        enable    = 1'b0;
        din       = '0;
        test_reset();
        test_idcode();
        test_pause();
        test_sticky_done();
        test_reset_mid_shift();
        test_edge_pattern();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
